// File: rtl/lm80c_pkg.sv
// Shared types and constants for the lm80c SDRAM arbiter.
// The CPU map places ROM and RAM at fixed bases inside the SDRAM.
package lm80c_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;
    typedef enum logic [1:0] {REQ_DL, REQ_ER, REQ_CPU} req_id_t;

    localparam logic [24:0] ROM_BASE = 25'h00000;
    localparam logic [24:0] RAM_BASE = 25'h10000;
endpackage

// File: rtl/lm80c_cpu_addr_map.sv
// Combinational Z80 address to SDRAM address mapping.
// The upper 32K is always RAM; the lower 32K is ROM while rom_en is set.
module lm80c_cpu_addr_map
    import lm80c_pkg::*;
#(
    parameter int ADDR_W = 25
) (
    input  logic [15:0]       cpu_addr,
    input  logic              rom_en,
    output logic [ADDR_W-1:0] sd_addr
);
    logic        ram;
    logic [24:0] full;

    assign ram     = ~rom_en | cpu_addr[15];
    assign full    = (ram ? RAM_BASE : ROM_BASE) | {9'd0, cpu_addr};
    assign sd_addr = ADDR_W'(full);
endmodule

// File: rtl/lm80c_sdram_arbiter.sv
// Slot-based scheduler sharing one SDRAM port between downloader, eraser and CPU.
// One access is issued per slot; CPU reads return data DATA_LAT clocks after issue.
module lm80c_sdram_arbiter
    import lm80c_pkg::*;
#(
    parameter int ADDR_W     = 25,
    parameter int DATA_LAT   = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              res_n_i,
    input  logic              slot_i,
    input  logic              dl_req_i,
    input  logic [ADDR_W-1:0] dl_addr_i,
    input  logic [7:0]        dl_din_i,
    output logic              dl_ack_o,
    input  logic              er_req_i,
    input  logic [ADDR_W-1:0] er_addr_i,
    input  logic [7:0]        er_din_i,
    output logic              er_ack_o,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [15:0]       cpu_addr_i,
    input  logic [7:0]        cpu_din_i,
    input  logic              rom_en_i,
    output logic              cpu_ack_o,
    output logic [7:0]        cpu_dout_o,
    output logic [ADDR_W-1:0] sd_addr_o,
    output logic [7:0]        sd_din_o,
    output logic              sd_we_o,
    output logic              sd_oe_o,
    input  logic [7:0]        sd_dout_i,
    output logic              busy_o
);
    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [2:0]    WAIT_LAST  = 3'(DATA_LAT - 2);

    state_t            state, state_nxt;
    req_id_t           owner, win;
    logic              win_vld, grant, armed, we_l;
    logic              rd_done, rd_ack, cpu_wr_ack;
    logic [2:0]        wcnt;
    logic [SW-1:0]     starve_cnt;
    logic [ADDR_W-1:0] cpu_sd_addr;

    lm80c_cpu_addr_map #(.ADDR_W(ADDR_W)) u_map (
        .cpu_addr (cpu_addr_i),
        .rom_en   (rom_en_i),
        .sd_addr  (cpu_sd_addr)
    );

    always_comb begin
        win_vld = dl_req_i | er_req_i | cpu_req_i;
        if (cpu_req_i && starve_cnt == STARVE_LIM) win = REQ_CPU;
        else if (dl_req_i)                         win = REQ_DL;
        else if (er_req_i)                         win = REQ_ER;
        else                                       win = REQ_CPU;
    end

    // armed stays low for the first edge after reset so a coincident slot is skipped
    assign grant  = (state == S_IDLE || state == S_HOLD) && slot_i && armed && win_vld;
    assign busy_o = (state != S_IDLE);

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        rd_done    = 1'b0;
        sd_we_o    = 1'b0;
        sd_oe_o    = 1'b0;
        dl_ack_o   = 1'b0;
        er_ack_o   = 1'b0;
        cpu_wr_ack = 1'b0;
        case (state)
            S_IDLE, S_HOLD: begin
                if (slot_i && armed) state_nxt = win_vld ? S_ISSUE : S_IDLE;
            end
            S_ISSUE: begin
                sd_we_o    = we_l;
                sd_oe_o    = ~we_l;
                dl_ack_o   = (owner == REQ_DL);
                er_ack_o   = (owner == REQ_ER);
                cpu_wr_ack = (owner == REQ_CPU) && we_l;
                if (we_l) begin
                    state_nxt = S_HOLD;
                end else if (DATA_LAT == 1) begin
                    rd_done   = 1'b1;
                    state_nxt = S_HOLD;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt == WAIT_LAST) begin
                    rd_done   = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign cpu_ack_o = cpu_wr_ack | rd_ack;

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            armed      <= 1'b0;
            owner      <= REQ_DL;
            we_l       <= 1'b0;
            sd_addr_o  <= '0;
            sd_din_o   <= '0;
            wcnt       <= '0;
            starve_cnt <= '0;
            cpu_dout_o <= '0;
            rd_ack     <= 1'b0;
        end else begin
            armed  <= 1'b1;
            rd_ack <= rd_done;
            wcnt   <= (state == S_WAIT) ? wcnt + 3'd1 : 3'd0;
            if (rd_done) cpu_dout_o <= sd_dout_i;
            if (grant) begin
                owner <= win;
                case (win)
                    REQ_DL: begin
                        sd_addr_o <= dl_addr_i;
                        sd_din_o  <= dl_din_i;
                        we_l      <= 1'b1;
                    end
                    REQ_ER: begin
                        sd_addr_o <= er_addr_i;
                        sd_din_o  <= er_din_i;
                        we_l      <= 1'b1;
                    end
                    default: begin
                        sd_addr_o <= cpu_sd_addr;
                        sd_din_o  <= cpu_din_i;
                        we_l      <= cpu_we_i;
                    end
                endcase
            end
            if (!cpu_req_i || (grant && win == REQ_CPU))      starve_cnt <= '0;
            else if (grant && starve_cnt != STARVE_LIM)       starve_cnt <= starve_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_lm80c_sdram_arbiter.sv
// Scoreboard bench: a slot-level reference model predicts each SDRAM command,
// a monitor compares the DUT's commands, acks and read data against it.
module tb_lm80c_sdram_arbiter;
    localparam int LAT  = 5;
    localparam int SMAX = 4;

    typedef struct {
        int         cyc;
        int         who;
        logic       we;
        logic [24:0] addr;
        logic [7:0] din;
        logic [7:0] rdata;
    } exp_t;
    typedef struct {
        int         due;
        logic [7:0] data;
    } rd_t;

    logic        clk = 0, res_n = 0, slot_i = 0;
    logic        dl_req = 0, er_req = 0, cpu_req = 0, cpu_we = 0, rom_en = 0;
    logic [24:0] dl_addr = 0, er_addr = 0;
    logic [7:0]  dl_din = 0, er_din = 0, cpu_din = 0, sd_dout = 0;
    logic [15:0] cpu_addr = 0;
    logic        dl_ack, er_ack, cpu_ack, sd_we, sd_oe, busy;
    logic [7:0]  cpu_dout, sd_din;
    logic [24:0] sd_addr;

    int   n_vec = 0, n_mis = 0, cyc = 0, ph = 0, cpu_ack_cnt = 0;
    bit   mode_rand = 0, er_hold = 0;
    exp_t exp_q[$];
    rd_t  rd_q[$];
    int   log_q[$];
    logic [7:0] mmem[int];
    logic [7:0] smem[int];

    lm80c_sdram_arbiter #(.ADDR_W(25), .DATA_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk_i(clk), .res_n_i(res_n), .slot_i(slot_i),
        .dl_req_i(dl_req), .dl_addr_i(dl_addr), .dl_din_i(dl_din), .dl_ack_o(dl_ack),
        .er_req_i(er_req), .er_addr_i(er_addr), .er_din_i(er_din), .er_ack_o(er_ack),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_din_i(cpu_din),
        .rom_en_i(rom_en), .cpu_ack_o(cpu_ack), .cpu_dout_o(cpu_dout),
        .sd_addr_o(sd_addr), .sd_din_o(sd_din), .sd_we_o(sd_we), .sd_oe_o(sd_oe),
        .sd_dout_i(sd_dout), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dflt(logic [24:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(string name);
        n_vec++;
        n_mis++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: one decision per slot from the priority and starvation rules.
    bit   armed_m = 0;
    int   starve_m = 0;
    exp_t e_m;
    always @(posedge clk) begin
        cyc++;
        if (!res_n) begin
            armed_m  = 0;
            starve_m = 0;
        end else begin
            if (slot_i && armed_m && (dl_req || er_req || cpu_req)) begin
                if (cpu_req && starve_m == SMAX) e_m.who = 2;
                else if (dl_req)                 e_m.who = 0;
                else if (er_req)                 e_m.who = 1;
                else                             e_m.who = 2;
                e_m.cyc   = cyc;
                e_m.rdata = 0;
                if (e_m.who == 0) begin
                    e_m.we = 1; e_m.addr = dl_addr; e_m.din = dl_din;
                end else if (e_m.who == 1) begin
                    e_m.we = 1; e_m.addr = er_addr; e_m.din = er_din;
                end else begin
                    e_m.we   = cpu_we;
                    e_m.din  = cpu_din;
                    e_m.addr = (rom_en && cpu_addr < 16'h8000) ? 25'(cpu_addr)
                                                               : 25'h10000 + 25'(cpu_addr);
                end
                if (e_m.we) mmem[int'(e_m.addr)] = e_m.din;
                else e_m.rdata = mmem.exists(int'(e_m.addr)) ? mmem[int'(e_m.addr)] : dflt(e_m.addr);
                exp_q.push_back(e_m);
                if (e_m.who == 2)                 starve_m = 0;
                else if (cpu_req && starve_m < SMAX) starve_m++;
            end
            if (!cpu_req) starve_m = 0;
            armed_m = 1;
        end
    end

    // SDRAM stand-in: data is valid only on the cycle sampled LAT edges after the slot.
    initial begin
        int rd_cnt;
        logic [24:0] rd_addr;
        rd_cnt  = -1;
        rd_addr = 0;
        forever begin
            @(negedge clk);
            if (res_n && sd_we) smem[int'(sd_addr)] = sd_din;
            if (res_n && sd_oe) begin
                rd_cnt  = 0;
                rd_addr = sd_addr;
            end else if (rd_cnt >= 0) rd_cnt++;
            if (rd_cnt == LAT - 1)
                sd_dout = smem.exists(int'(rd_addr)) ? smem[int'(rd_addr)] : dflt(rd_addr);
            else
                sd_dout = 8'($urandom);
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (res_n) begin
            exp_t e;
            rd_t  r;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                void'(exp_q.pop_front());
                flag("missed_cmd");
            end
            while (rd_q.size() > 0 && rd_q[0].due < cyc) begin
                void'(rd_q.pop_front());
                flag("missed_rd_ack");
            end
            if (sd_we || sd_oe) begin
                log_q.push_back(dl_ack ? 0 : er_ack ? 1 : 2);
                if (exp_q.size() == 0) flag("unexp_cmd");
                else begin
                    e = exp_q.pop_front();
                    chk("cmd_cycle", cyc, e.cyc);
                    chk("cmd_addr", sd_addr, e.addr);
                    chk("cmd_we_oe", {sd_we, sd_oe}, {e.we, ~e.we});
                    if (e.we) chk("cmd_din", sd_din, e.din);
                    chk("issue_acks", {dl_ack, er_ack, cpu_ack},
                        e.we ? (3'b100 >> e.who) : 3'b000);
                    chk("busy_issue", busy, 1'b1);
                    if (!e.we) begin
                        r.due  = cyc + LAT;
                        r.data = e.rdata;
                        rd_q.push_back(r);
                    end
                end
            end else begin
                if (dl_ack || er_ack) flag("unexp_wr_ack");
                if (cpu_ack) begin
                    if (rd_q.size() == 0) flag("unexp_cpu_ack");
                    else begin
                        r = rd_q.pop_front();
                        chk("rd_ack_cycle", cyc, r.due);
                        chk("rd_data", cpu_dout, r.data);
                    end
                end
            end
            if (cpu_ack) cpu_ack_cnt++;
        end
    end

    // Slot strobe and requester drivers
    initial begin
        forever begin
            @(negedge clk);
            ph     = (ph + 1) % 8;
            slot_i = (ph == 0);
            if (dl_ack) dl_req = 0;
            if (er_ack && !er_hold) er_req = 0;
            if (cpu_ack) cpu_req = 0;
            if (mode_rand) begin
                if (!dl_req && $urandom_range(15) == 0) begin
                    dl_req = 1; dl_addr = 25'($urandom); dl_din = 8'($urandom);
                end
                if (!er_req && $urandom_range(11) == 0) begin
                    er_req = 1; er_addr = 25'($urandom); er_din = 8'($urandom);
                end
                if (cpu_req && ph == 7 && $urandom_range(9) == 0) cpu_req = 0;
                else if (!cpu_req && $urandom_range(3) == 0) begin
                    cpu_req  = 1;
                    cpu_we   = 1'($urandom);
                    rom_en   = 1'($urandom);
                    cpu_addr = 16'($urandom);
                    cpu_din  = 8'($urandom);
                end
            end
        end
    end

    task automatic wait_ph(int p);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            #1;
            if (ph == p) break;
        end
    endtask

    task automatic release_reset();
        wait_ph(3);
        res_n = 1;
    endtask

    initial begin
        int exp4[6];
        exp4 = '{1, 1, 1, 1, 2, 1};
        repeat (3) @(negedge clk);
        #1;
        chk("rst_addr", sd_addr, 25'h0);
        chk("rst_cmd", {sd_we, sd_oe}, 2'b00);
        chk("rst_acks", {dl_ack, er_ack, cpu_ack}, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dout", cpu_dout, 8'h00);
        release_reset();

        // ROM read at 0x0123
        mmem[32'h123] = 8'hA5;
        smem[32'h123] = 8'hA5;
        rom_en = 1; cpu_we = 0; cpu_addr = 16'h0123; cpu_req = 1;
        repeat (24) @(negedge clk);
        #1;
        chk("t1_dout", cpu_dout, 8'hA5);

        // RAM write with ROM disabled
        rom_en = 0; cpu_we = 1; cpu_addr = 16'h0010; cpu_din = 8'h3C; cpu_req = 1;
        repeat (16) @(negedge clk);
        #1;
        chk("t2_addr_held", sd_addr, 25'h10010);
        chk("t2_din_held", sd_din, 8'h3C);

        // All three in the same slot
        log_q.delete();
        wait_ph(2);
        dl_req = 1; dl_addr = 25'h1ABCD; dl_din = 8'h11;
        er_req = 1; er_addr = 25'h00777; er_din = 8'h22;
        rom_en = 1; cpu_we = 1; cpu_addr = 16'h9000; cpu_din = 8'h33; cpu_req = 1;
        repeat (32) @(negedge clk);
        #1;
        chk("t3_count", log_q.size(), 3);
        for (int i = 0; i < 3 && i < log_q.size(); i++) chk("t3_order", log_q[i], i);

        // Continuous eraser starves the CPU for at most four slots
        repeat (8) @(negedge clk);
        #1;
        log_q.delete();
        er_hold = 1; er_req = 1; er_addr = 25'h0F000; er_din = 8'h44;
        cpu_we = 1; cpu_addr = 16'h8001; cpu_din = 8'h55; cpu_req = 1;
        for (int i = 0; i < 100 && log_q.size() < 6; i++) @(negedge clk);
        #1;
        er_hold = 0; er_req = 0;
        chk("t4_count_ok", log_q.size() >= 6, 1'b1);
        for (int i = 0; i < 6 && i < log_q.size(); i++) chk("t4_order", log_q[i], exp4[i]);

        // Reset during the read wait
        repeat (16) @(negedge clk);
        #1;
        rom_en = 1; cpu_we = 0; cpu_addr = 16'h0200; cpu_req = 1;
        for (int i = 0; i < 20 && !sd_oe; i++) @(negedge clk);
        chk("t5_read_issued", sd_oe, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        chk("t5_busy_pre", busy, 1'b1);
        res_n = 0;
        #1;
        chk("t5_cmd_drop", {sd_we, sd_oe}, 2'b00);
        chk("t5_acks_drop", {dl_ack, er_ack, cpu_ack}, 3'b000);
        chk("t5_busy_drop", busy, 1'b0);
        cpu_req = 0;
        exp_q.delete();
        rd_q.delete();
        cpu_ack_cnt = 0;
        repeat (3) @(negedge clk);
        release_reset();
        repeat (24) @(negedge clk);
        #1;
        chk("t5_no_late_ack", cpu_ack_cnt, 0);

        // Request withdrawn just before the slot
        repeat (16) @(negedge clk);
        wait_ph(2);
        rom_en = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_din = 8'h66; cpu_req = 1;
        wait_ph(7);
        cpu_req = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("t6_busy", busy, 1'b0);
            chk("t6_cmd", {sd_we, sd_oe}, 2'b00);
        end

        // Random traffic
        mode_rand = 1;
        repeat (1200) @(negedge clk);
        mode_rand = 0;
        for (int i = 0; i < 200 && (dl_req || er_req || cpu_req); i++) @(negedge clk);
        chk("drain_reqs", {dl_req, er_req, cpu_req}, 3'b000);
        repeat (16) @(negedge clk);
        #1;
        chk("drain_exp_q", exp_q.size(), 0);
        chk("drain_rd_q", rd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/lm80c_sdram_arbiter.md
# lm80c_sdram_arbiter

Clocked arbiter that shares the single SDRAM controller port between three requesters: the ROM/PRG downloader, the RAM eraser and the Z80 CPU. It replaces the combinational priority mux in the top level with a slot-based scheduler. The scheduler maps CPU addresses into the ROM/RAM layout, issues one access per SDRAM slot, returns per-requester acknowledges and holds CPU read data stable. It sits between the lm80c core, downloader, eraser and the `sdram` instance, all on `sys_clock`.

## Interface
- `ADDR_W`, 25: SDRAM byte-address width.
- `DATA_LAT`, 5: clocks from the issue cycle (`slot_i` high) to valid `sd_dout_i`; legal range 1..7.
- `STARVE_MAX`, 4: consecutive granted non-CPU slots after which a pending CPU request wins the next slot.
- `clk_i` in 1: `sys_clock`; all logic on its rising edge.
- `res_n_i` in 1: asynchronous, active-low reset.
- `slot_i` in 1: one-cycle strobe, once per 8 clocks, aligned to the controller's `clkref` phase.
- `dl_req_i` in 1, `dl_addr_i` in ADDR_W, `dl_din_i` in 8: downloader write request, level, held until ack.
- `dl_ack_o` out 1: one-cycle pulse when the downloader write has been issued.
- `er_req_i` in 1, `er_addr_i` in ADDR_W, `er_din_i` in 8: eraser write request, level.
- `er_ack_o` out 1: one-cycle issue pulse.
- `cpu_req_i` in 1, `cpu_we_i` in 1, `cpu_addr_i` in 16, `cpu_din_i` in 8: CPU access, level.
- `rom_en_i` in 1: PIO B bit 0.
- `cpu_ack_o` out 1: one-cycle pulse. For a write it pulses on issue; for a read it pulses when data is valid.
- `cpu_dout_o` out 8: last CPU read data, registered.
- `sd_addr_o` out ADDR_W, `sd_din_o` out 8, `sd_we_o` out 1, `sd_oe_o` out 1: to the `sdram` controller.
- `sd_dout_i` in 8: from the `sdram` controller.
- `busy_o` out 1: an access is in flight.

## Operation
- CPU address map, evaluated at grant:
  - `sd_addr = {8'd0, ram, cpu_addr}` with `ram = ~rom_en_i | cpu_addr[15]`.
  - ROM occupies 0x00000–0x07FFF; RAM occupies 0x10000–0x1FFFF.
- Requester addresses are 25 bits; a requester that already supplies 25-bit addresses passes through unchanged.
- Priority at each `slot_i`: downloader > eraser > CPU.
  - Exception: if `starve_cnt == STARVE_MAX` and `cpu_req_i` is high, the CPU wins.
  - `starve_cnt` increments on each non-CPU grant while `cpu_req_i` is high. It clears on a CPU grant or when `cpu_req_i` is low. It saturates at STARVE_MAX.
- FSM states:
  - IDLE: on `slot_i` with any request, latch the winner, drive `sd_*` and go to ISSUE.
  - ISSUE: `sd_we_o`/`sd_oe_o` are asserted for exactly one clock and the ack pulses for writes. The next state is WAIT for reads, otherwise HOLD.
  - WAIT: count `DATA_LAT-1` clocks, then capture `sd_dout_i` into `cpu_dout_o`, pulse `cpu_ack_o` and go to HOLD.
  - HOLD: stay until the next `slot_i`, then re-arbitrate as in IDLE. No back-to-back issue within one slot.
- Only the CPU issues reads. Downloader and eraser accesses are always writes.
- `sd_addr_o`/`sd_din_o` hold their latched value from ISSUE until the next grant.
- An access is never pre-empted once latched.
- A request dropped before grant is discarded silently.
- If `cpu_req_i` stays high after ack, it is treated as a new request at the next slot. The CPU wrapper deasserts it on ack.

## Timing
- Reset values: all outputs 0, FSM in IDLE, `starve_cnt` 0.
- Reset mid-access: the access is aborted, `sd_we_o`/`sd_oe_o` drop immediately (asynchronous), and no ack is issued.
- Grant latency: requester stable before the `slot_i` edge → ISSUE on the following clock.
- Write ack: 1 clock after the slot.
- Read ack: `DATA_LAT` clocks after ISSUE.
- `busy_o` is high from ISSUE through the last HOLD clock.
- Simultaneous `slot_i` and `res_n_i` deassertion: the slot is ignored, and the first grant is at the next slot.
- Minimum throughput: one access per slot, i.e. one per 8 clocks.

## Structure
- Package `lm80c_pkg`:
  - FSM state enum.
  - Requester id enum: DL, ER, CPU.
  - Constants `ROM_BASE = 25'h00000` and `RAM_BASE = 25'h10000`.
- One sub-module, `lm80c_cpu_addr_map`: the combinational CPU address mapping, reused by the debug/monitor path.

## Test plan
- Reset, then CPU read with `rom_en=1` at 0x0123 → `sd_addr_o = 0x00123`, `sd_oe_o` high for 1 clock, `cpu_ack_o` 5 clocks later with model data 0xA5 on `cpu_dout_o`.
- `rom_en=0`, CPU write 0x3C to 0x0010 → `sd_addr_o = 0x10010`, `sd_din_o = 0x3C`, `sd_we_o` pulse, `cpu_ack_o` 1 clock after the slot.
- Downloader, eraser and CPU all request in the same slot → grant order DL, ER, CPU on three successive slots, each with the matching ack.
- Eraser requests continuously while the CPU waits → CPU granted on the 5th slot (after 4 eraser grants), then the eraser resumes.
- Reset asserted during WAIT of a CPU read → `sd_oe_o` and all acks go 0 immediately, and no `cpu_ack_o` appears after release.
- `cpu_req_i` dropped one clock before the slot, with no other requester → no SDRAM command and `busy_o` stays 0.
